// File: rtl/io_write_arbiter.sv
// Two-requester round-robin write arbiter feeding a single I/O output register.
// Optional invalid-address error tracking is built when IO_ARB_ERR_EN is defined.
module io_write_arbiter (
  input  logic        io_clk,
  input  logic        clrn,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic        err_clr,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        write_io_enable,
  output logic        busy,
  output logic        grant_id,
  output logic        err_flag,
  output logic [7:0]  err_count
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [0:0]  r_state;
  logic        r_last;      // last-served requester; reset to 1 so requester 0 wins first
  logic        r_grant;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_wen;
  logic        r_ack0;
  logic        r_ack1;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_any;
  logic        w_win;
  logic [31:0] w_win_addr;
  logic [31:0] w_win_data;
  logic        w_win_ok;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[7:2] == 6'h20) || (a[7:2] == 6'h21) || (a[7:2] == 6'h22);
  endfunction

  // The requester being served this cycle is masked so the other one can follow back-to-back.
  assign w_elig0    = req0 && !((r_state == ST_WRITE) && (r_grant == 1'b0));
  assign w_elig1    = req1 && !((r_state == ST_WRITE) && (r_grant == 1'b1));
  assign w_any      = w_elig0 || w_elig1;
  assign w_win      = (w_elig0 && w_elig1) ? ~r_last : w_elig1;
  assign w_win_addr = w_win ? addr1 : addr0;
  assign w_win_data = w_win ? data1 : data0;
  assign w_win_ok   = addr_ok(w_win_addr);

  // NOTE: the reset branch is asynchronous (in the sensitivity list), so clrn clears
  // state immediately, including in the middle of a WRITE cycle.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_wen   <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults followed by conditional overrides give single-cycle
      // pulses; the last non-blocking assignment in the block wins.
      r_wen  <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (r_state == ST_WRITE) r_last <= r_grant;
      if (w_any) begin
        r_state <= ST_WRITE;
        r_grant <= w_win;
        r_addr  <= w_win_addr;
        r_data  <= w_win_data;
        r_wen   <= w_win_ok;
        r_ack0  <= ~w_win;
        r_ack1  <= w_win;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign addr            = r_addr;
  assign datain          = r_data;
  assign write_io_enable = r_wen;
  assign ack0            = r_ack0;
  assign ack1            = r_ack1;
  assign busy            = (r_state == ST_WRITE);
  assign grant_id        = r_grant;

`ifdef IO_ARB_ERR_EN
  logic       r_err_flag;
  logic [7:0] r_err_count;
  logic       w_err_hit;

  // Errors are booked at capture so the flag rises together with the failing ack.
  assign w_err_hit = w_any && !w_win_ok;

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      r_err_flag  <= 1'b0;
      r_err_count <= 8'h00;
    end else if (err_clr) begin
      r_err_flag  <= 1'b0;
      r_err_count <= 8'h00;
    end else if (w_err_hit) begin
      r_err_flag <= 1'b1;
      if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'h01;
    end
  end

  assign err_flag  = r_err_flag;
  assign err_count = r_err_count;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_flag         = 1'b0;
  assign err_count        = 8'h00;
`endif

endmodule
